hpdcache_store_limiter: RTL and testbench

- Sits between the CVA6 store unit and the HPDcache write request port.
- Tags each accepted store with a free transaction ID (TID).
- Caps in-flight stores at MaxOutstandingStores, frees TIDs on write responses, and provides a fence drain handshake.
- Downstream consumer of the core config fields MaxOutstandingStores and DcacheIdWidth.

---
 rtl/hpdcache_store_limiter.sv | 118 +++++++++++
 tb/tb_hpdcache_store_limiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdcache_store_limiter.sv
// Store limiter between the CVA6 store unit and the HPDcache write port:
// tags stores with free TIDs, caps in-flight stores and runs the fence drain handshake.
module hpdcache_store_limiter #(
   parameter int unsigned MaxOutstandingStores = 7,
   parameter int unsigned TidWidth             = 3,
   parameter int unsigned AddrWidth            = 64,
   parameter int unsigned DataWidth            = 64,
   localparam int unsigned NumTid   = 2 ** TidWidth,
   localparam int unsigned Cap      = (MaxOutstandingStores < NumTid) ? MaxOutstandingStores : NumTid,
   localparam int unsigned CntWidth = $clog2(Cap + 1),
   localparam int unsigned BeWidth  = DataWidth / 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 st_valid_i,
   output logic                 st_ready_o,
   input  logic [AddrWidth-1:0] st_addr_i,
   input  logic [DataWidth-1:0] st_data_i,
   input  logic [BeWidth-1:0]   st_be_i,
   output logic                 dc_valid_o,
   input  logic                 dc_ready_i,
   output logic [AddrWidth-1:0] dc_addr_o,
   output logic [DataWidth-1:0] dc_data_o,
   output logic [BeWidth-1:0]   dc_be_o,
   output logic [TidWidth-1:0]  dc_tid_o,
   input  logic                 rsp_valid_i,
   input  logic [TidWidth-1:0]  rsp_tid_i,
   input  logic                 drain_req_i,
   output logic                 drained_o,
   output logic [CntWidth-1:0]  outstanding_o,
   output logic                 spurious_o,
   output logic [1:0]           fsm_state_o
);

   // Handshake: dc_valid_o is computed without looking at dc_ready_i; a
   // store transfers (and st_ready_o rises) only when valid and ready are both high.

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   state_e              state, state_next;
   logic [NumTid-1:0]   bitmap, bitmap_next;
   logic [CntWidth-1:0] cnt, cnt_next;
   logic                spurious_q;
   logic [TidWidth-1:0] free_tid;
   logic                full;
   logic                alloc;
   logic                free_hit;

   // Lowest clear TID, looking at the registered bitmap only.
   always_comb begin
      logic found;
      free_tid = '0;
      found    = 1'b0;
      for (int i = 0; i < NumTid; i++) begin
         if (!found && !bitmap[i]) begin
            free_tid = TidWidth'(i);
            found    = 1'b1;
         end
      end
   end

   assign full       = (cnt == CntWidth'(Cap));
   assign dc_valid_o = st_valid_i && !full && (state == ST_IDLE);
   assign st_ready_o = dc_valid_o && dc_ready_i;
   assign dc_addr_o  = st_addr_i;
   assign dc_data_o  = st_data_i;
   assign dc_be_o    = st_be_i;
   assign dc_tid_o   = free_tid;

   assign alloc    = st_ready_o;
   assign free_hit = rsp_valid_i && bitmap[rsp_tid_i];

   // alloc and free never hit the same TID: the allocated bit is clear in bitmap.
   always_comb begin
      bitmap_next = bitmap;
      if (alloc)    bitmap_next[free_tid]  = 1'b1;
      if (free_hit) bitmap_next[rsp_tid_i] = 1'b0;
      case ({alloc, free_hit})
         2'b10:   cnt_next = cnt + 1'b1;
         2'b01:   cnt_next = cnt - 1'b1;
         default: cnt_next = cnt;
      endcase
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (drain_req_i) state_next = ST_DRAIN;
         ST_DRAIN: if (cnt == '0)   state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= ST_IDLE;
         bitmap     <= '0;
         cnt        <= '0;
         spurious_q <= 1'b0;
      end else begin
         state      <= state_next;
         bitmap     <= bitmap_next;
         cnt        <= cnt_next;
         spurious_q <= rsp_valid_i && !bitmap[rsp_tid_i];
      end
   end

   assign drained_o     = (state == ST_DONE);
   assign outstanding_o = cnt;
   assign spurious_o    = spurious_q;
   assign fsm_state_o   = state;

endmodule

// File: tb/tb_hpdcache_store_limiter.sv
// Directed bench for hpdcache_store_limiter: TID allocation, cap, backpressure,
// simultaneous alloc/free, fence drain, spurious responses and reset.
module tb_hpdcache_store_limiter;

   logic        clk;
   logic        rst;
   logic        st_valid;
   logic        st_ready;
   logic [63:0] st_addr;
   logic [63:0] st_data;
   logic [7:0]  st_be;
   logic        dc_valid;
   logic        dc_ready;
   logic [63:0] dc_addr;
   logic [63:0] dc_data;
   logic [7:0]  dc_be;
   logic [2:0]  dc_tid;
   logic        rsp_valid;
   logic [2:0]  rsp_tid;
   logic        drain_req;
   logic        drained;
   logic [2:0]  outstanding;
   logic        spurious;
   logic [1:0]  fsm_state;

   int total = 0;
   int bad   = 0;

   hpdcache_store_limiter dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .st_valid_i   (st_valid),
      .st_ready_o   (st_ready),
      .st_addr_i    (st_addr),
      .st_data_i    (st_data),
      .st_be_i      (st_be),
      .dc_valid_o   (dc_valid),
      .dc_ready_i   (dc_ready),
      .dc_addr_o    (dc_addr),
      .dc_data_o    (dc_data),
      .dc_be_o      (dc_be),
      .dc_tid_o     (dc_tid),
      .rsp_valid_i  (rsp_valid),
      .rsp_tid_i    (rsp_tid),
      .drain_req_i  (drain_req),
      .drained_o    (drained),
      .outstanding_o(outstanding),
      .spurious_o   (spurious),
      .fsm_state_o  (fsm_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; land 1 ns after the edge and check cnt == popcount(bitmap).
   task automatic step();
      @(posedge clk);
      #1;
      total++;
      if ($countones(dut.bitmap) !== int'(dut.cnt)) begin
         bad++;
         $display("FAIL invariant: cnt=%0d popcount(bitmap)=%0d", dut.cnt, $countones(dut.bitmap));
      end
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      st_valid  = 1'b0;
      dc_ready  = 1'b1;
      st_addr   = '0;
      st_data   = '0;
      st_be     = '0;
      rsp_valid = 1'b0;
      rsp_tid   = '0;
      drain_req = 1'b0;
      step();
      rst = 1'b0;
   endtask

   // Issue n stores with dc_ready high; expects TIDs first_tid, first_tid+1, ...
   task automatic push_stores(input int n, input int first_tid);
      for (int i = 0; i < n; i++) begin
         st_valid = 1'b1;
         st_addr  = 64'h8000_0000 + 64'(i * 8);
         st_data  = {32'hA5A5_0000, 32'(i)};
         st_be    = 8'hFF;
         #1;
         total++;
         if (st_ready !== 1'b1 || dc_tid !== 3'(first_tid + i)) begin
            bad++;
            $display("FAIL push_store[%0d]: ready=%b tid=%0d want ready=1 tid=%0d", i, st_ready, dc_tid, first_tid + i);
         end
         step();
      end
      st_valid = 1'b0;
   endtask

   task automatic respond(input logic [2:0] tid);
      rsp_valid = 1'b1;
      rsp_tid   = tid;
      step();
      rsp_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      total++;
      if (outstanding !== 3'd0 || drained !== 1'b0 || spurious !== 1'b0 ||
          dc_tid !== 3'd0 || dc_valid !== 1'b0 || st_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset: outs=%0d drained=%b spur=%b tid=%0d valid=%b ready=%b want all 0",
                  outstanding, drained, spurious, dc_tid, dc_valid, st_ready);
      end
   endtask

   task automatic test_basic();
      logic [2:0] order [3];
      logic [2:0] exp_outs [3];
      order    = '{3'd1, 3'd0, 3'd2};
      exp_outs = '{3'd2, 3'd1, 3'd0};
      do_reset();
      st_valid = 1'b1;
      st_addr  = 64'hDEAD_BEEF_0000_1230;
      st_data  = 64'h0123_4567_89AB_CDEF;
      st_be    = 8'h3C;
      #1;
      total++;
      if (dc_addr !== 64'hDEAD_BEEF_0000_1230 || dc_data !== 64'h0123_4567_89AB_CDEF || dc_be !== 8'h3C) begin
         bad++;
         $display("FAIL passthrough: addr=%h data=%h be=%h want DEADBEEF00001230 0123456789ABCDEF 3C",
                  dc_addr, dc_data, dc_be);
      end
      st_valid = 1'b0;
      push_stores(3, 0);
      #1;
      total++;
      if (outstanding !== 3'd3 || dc_tid !== 3'd3) begin
         bad++;
         $display("FAIL basic_outstanding: outs=%0d tid=%0d want 3 3", outstanding, dc_tid);
      end
      for (int i = 0; i < 3; i++) begin
         respond(order[i]);
         total++;
         if (outstanding !== exp_outs[i] || spurious !== 1'b0) begin
            bad++;
            $display("FAIL basic_free[%0d]: outs=%0d spur=%b want %0d 0", i, outstanding, spurious, exp_outs[i]);
         end
      end
   endtask

   task automatic test_full();
      do_reset();
      push_stores(7, 0);
      st_valid = 1'b1;
      #1;
      total++;
      if (outstanding !== 3'd7 || st_ready !== 1'b0 || dc_valid !== 1'b0) begin
         bad++;
         $display("FAIL full_block: outs=%0d ready=%b valid=%b want 7 0 0", outstanding, st_ready, dc_valid);
      end
      // Response for TID 3 arrives while full: no same-cycle bypass.
      rsp_valid = 1'b1;
      rsp_tid   = 3'd3;
      #1;
      total++;
      if (st_ready !== 1'b0 || dc_valid !== 1'b0) begin
         bad++;
         $display("FAIL full_no_bypass: ready=%b valid=%b want 0 0", st_ready, dc_valid);
      end
      step();
      rsp_valid = 1'b0;
      #1;
      total++;
      if (dc_tid !== 3'd3 || st_ready !== 1'b1 || outstanding !== 3'd6) begin
         bad++;
         $display("FAIL full_reuse: tid=%0d ready=%b outs=%0d want 3 1 6", dc_tid, st_ready, outstanding);
      end
      step();
      st_valid = 1'b0;
      st_valid = 1'b1;
      #1;
      total++;
      if (outstanding !== 3'd7 || dc_valid !== 1'b0) begin
         bad++;
         $display("FAIL full_again: outs=%0d valid=%b want 7 0", outstanding, dc_valid);
      end
      st_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      do_reset();
      st_valid = 1'b1;
      dc_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         total++;
         if (dc_valid !== 1'b1 || st_ready !== 1'b0 || dc_tid !== 3'd0) begin
            bad++;
            $display("FAIL backpressure[%0d]: valid=%b ready=%b tid=%0d want 1 0 0", c, dc_valid, st_ready, dc_tid);
         end
         step();
      end
      total++;
      if (outstanding !== 3'd0) begin
         bad++;
         $display("FAIL backpressure_cnt: outs=%0d want 0", outstanding);
      end
      st_valid = 1'b0;
      dc_ready = 1'b1;
   endtask

   task automatic test_simultaneous();
      do_reset();
      push_stores(2, 0);
      st_valid  = 1'b1;
      rsp_valid = 1'b1;
      rsp_tid   = 3'd0;
      #1;
      total++;
      if (st_ready !== 1'b1 || dc_tid !== 3'd2) begin
         bad++;
         $display("FAIL simul_accept: ready=%b tid=%0d want 1 2", st_ready, dc_tid);
      end
      step();
      st_valid  = 1'b0;
      rsp_valid = 1'b0;
      #1;
      total++;
      if (outstanding !== 3'd2 || dc_tid !== 3'd0 || spurious !== 1'b0) begin
         bad++;
         $display("FAIL simul_state: outs=%0d tid=%0d spur=%b want 2 0 0", outstanding, dc_tid, spurious);
      end
      push_stores(1, 0);
      #1;
      total++;
      if (outstanding !== 3'd3 || dc_tid !== 3'd3) begin
         bad++;
         $display("FAIL simul_next: outs=%0d tid=%0d want 3 3", outstanding, dc_tid);
      end
   endtask

   task automatic test_drain();
      logic exp_drained;
      logic exp_ready;
      do_reset();
      push_stores(2, 0);
      drain_req = 1'b1;
      step();
      drain_req = 1'b0;
      st_valid  = 1'b1;
      // Now at cycle +1 relative to the drain pulse.
      for (int cyc = 1; cyc <= 8; cyc++) begin
         exp_drained = (cyc == 7);
         exp_ready   = (cyc == 8);
         #1;
         total++;
         if (drained !== exp_drained || st_ready !== exp_ready) begin
            bad++;
            $display("FAIL drain_cyc%0d: drained=%b ready=%b want %b %b", cyc, drained, st_ready, exp_drained, exp_ready);
         end
         rsp_valid = (cyc == 3) || (cyc == 5);
         rsp_tid   = (cyc == 3) ? 3'd0 : 3'd1;
         step();
         rsp_valid = 1'b0;
      end
      st_valid = 1'b0;
      respond(3'd0);
      // Drain with nothing in flight: pulse two cycles later.
      drain_req = 1'b1;
      step();
      drain_req = 1'b0;
      for (int cyc = 1; cyc <= 3; cyc++) begin
         exp_drained = (cyc == 2);
         #1;
         total++;
         if (drained !== exp_drained || outstanding !== 3'd0) begin
            bad++;
            $display("FAIL drain_empty_cyc%0d: drained=%b outs=%0d want %b 0", cyc, drained, outstanding, exp_drained);
         end
         step();
      end
      // Store presented with the drain request is still accepted.
      st_valid  = 1'b1;
      drain_req = 1'b1;
      #1;
      total++;
      if (st_ready !== 1'b1) begin
         bad++;
         $display("FAIL drain_same_cycle: ready=%b want 1", st_ready);
      end
      step();
      drain_req = 1'b0;
      #1;
      total++;
      if (outstanding !== 3'd1 || st_ready !== 1'b0) begin
         bad++;
         $display("FAIL drain_same_cycle_after: outs=%0d ready=%b want 1 0", outstanding, st_ready);
      end
      st_valid = 1'b0;
      respond(3'd0);
      step();
      total++;
      if (drained !== 1'b1) begin
         bad++;
         $display("FAIL drain_same_cycle_done: drained=%b want 1", drained);
      end
      step();
   endtask

   task automatic test_spurious_reset();
      do_reset();
      respond(3'd5);
      total++;
      if (spurious !== 1'b1 || outstanding !== 3'd0) begin
         bad++;
         $display("FAIL spurious_pulse: spur=%b outs=%0d want 1 0", spurious, outstanding);
      end
      step();
      total++;
      if (spurious !== 1'b0) begin
         bad++;
         $display("FAIL spurious_single: spur=%b want 0", spurious);
      end
      push_stores(4, 0);
      rst      = 1'b1;
      st_valid = 1'b1;
      step();
      rst      = 1'b0;
      st_valid = 1'b0;
      #1;
      total++;
      if (outstanding !== 3'd0 || dc_tid !== 3'd0 || drained !== 1'b0 ||
          spurious !== 1'b0 || dc_valid !== 1'b0 || st_ready !== 1'b0) begin
         bad++;
         $display("FAIL midreset: outs=%0d tid=%0d drained=%b spur=%b valid=%b ready=%b want all 0",
                  outstanding, dc_tid, drained, spurious, dc_valid, st_ready);
      end
      respond(3'd2);
      total++;
      if (spurious !== 1'b1 || outstanding !== 3'd0) begin
         bad++;
         $display("FAIL stale_tid: spur=%b outs=%0d want 1 0", spurious, outstanding);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_backpressure();
      test_simultaneous();
      test_drain();
      test_spurious_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
